// File: rtl/mmio_button_ctrl.sv
// MMIO bridge between the data-memory port, the push-buttons and the VGA output register.
// Buttons are synchronised, debounced and latched as sticky press events that clear on read.
module mmio_button_ctrl #(
    parameter int unsigned NUM_BTN         = 5,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned BTN_BASE        = 3000,
    parameter int unsigned BTN_STRIDE      = 1000,
    parameter int unsigned OUT_ADDR        = 2000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_BTN-1:0]  btn_raw,
    input  logic [31:0]         address_dmem,
    input  logic                wren,
    input  logic                rden,
    input  logic [31:0]         data,
    input  logic [31:0]         mem_q,
    output logic [31:0]         q_dmem,
    output logic [31:0]         out_data,
    output logic                out_valid,
    output logic [NUM_BTN-1:0]  btn_level
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [NUM_BTN-1:0] sync1;
    logic [NUM_BTN-1:0] sync2;
    logic [CW-1:0]      cnt [NUM_BTN];
    logic [NUM_BTN-1:0] sticky;

    logic [NUM_BTN-1:0] hit_btn_c;
    logic               hit_out_c;
    logic               rd_c;
    logic [NUM_BTN-1:0] clr_c;
    logic [NUM_BTN-1:0] rise_c;
    logic [31:0]        rdata_c;

    // Address decode, read mux, clear-on-read and rising-edge detect
    always_comb begin
        hit_btn_c = '0;
        rise_c    = '0;
        hit_out_c = (address_dmem == 32'(OUT_ADDR));
        rd_c      = rden & ~wren;
        rdata_c   = mem_q;
        for (int i = 0; i < NUM_BTN; i++) begin
            hit_btn_c[i] = (address_dmem == 32'(BTN_BASE + i * BTN_STRIDE));
            rise_c[i]    = sync2[i] & ~btn_level[i] & (cnt[i] == CNT_LAST);
        end
        clr_c = rd_c ? hit_btn_c : '0;
        if (rd_c) begin
            if (hit_out_c) rdata_c = out_data;
            for (int i = 0; i < NUM_BTN; i++) begin
                if (hit_btn_c[i]) rdata_c = {30'b0, sticky[i], btn_level[i]};
            end
        end
    end

    // Synchroniser and per-channel debounce counters
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1     <= '0;
            sync2     <= '0;
            btn_level <= '0;
            for (int i = 0; i < NUM_BTN; i++) cnt[i] <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            for (int i = 0; i < NUM_BTN; i++) begin
                if (sync2[i] == btn_level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    btn_level[i] <= sync2[i];
                    cnt[i]       <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    // Sticky press bits: a new press on the same edge as a clearing read is kept
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sticky <= '0;
        end else begin
            sticky <= rise_c | (sticky & ~clr_c);
        end
    end

    // Registered read data and output store register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q_dmem    <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            q_dmem    <= rdata_c;
            out_valid <= wren & hit_out_c;
            if (wren && hit_out_c) out_data <= data;
        end
    end

endmodule

// File: tb/tb_mmio_button_ctrl.sv
// Directed self-checking bench for mmio_button_ctrl: reset, debounce, sticky reads,
// set-wins, output store and pass-through, each in its own task.
module tb_mmio_button_ctrl;

    logic        clock;
    logic        reset;
    logic [4:0]  btn_raw;
    logic [31:0] address_dmem;
    logic        wren;
    logic        rden;
    logic [31:0] data;
    logic [31:0] mem_q;
    logic [31:0] q_dmem;
    logic [31:0] out_data;
    logic        out_valid;
    logic [4:0]  btn_level;

    int checks = 0;
    int errors = 0;

    mmio_button_ctrl dut (
        .clock        (clock),
        .reset        (reset),
        .btn_raw      (btn_raw),
        .address_dmem (address_dmem),
        .wren         (wren),
        .rden         (rden),
        .data         (data),
        .mem_q        (mem_q),
        .q_dmem       (q_dmem),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .btn_level    (btn_level)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Advance one edge; outputs are observed 1 time unit after it
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset        = 1'b1;
        btn_raw      = '0;
        address_dmem = '0;
        wren         = 1'b0;
        rden         = 1'b0;
        data         = '0;
        mem_q        = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] addr);
        address_dmem = addr;
        rden         = 1'b1;
        wren         = 1'b0;
        tick();
        rden         = 1'b0;
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [31:0] val);
        address_dmem = addr;
        data         = val;
        wren         = 1'b1;
        rden         = 1'b0;
        tick();
        wren         = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({q_dmem, out_data, out_valid, btn_level} !== '0) begin
            errors++;
            $display("FAIL reset_state: q=%h od=%h ov=%b lvl=%b, required all zero",
                     q_dmem, out_data, out_valid, btn_level);
        end
        mem_q = 32'h77;
        do_load(32'd12);
        checks++;
        if (q_dmem !== 32'h77) begin
            errors++;
            $display("FAIL reset_first_load: got %h required 00000077", q_dmem);
        end
        // Build up nonzero state, then reset mid-cycle
        btn_raw[3] = 1'b1;
        repeat (7) tick();
        do_store(32'd2000, 32'hCAFEF00D);
        checks++;
        if (out_valid !== 1'b1 || btn_level[3] !== 1'b1 || q_dmem !== 32'h77) begin
            errors++;
            $display("FAIL reset_prestate: ov=%b lvl3=%b q=%h required 1 1 00000077",
                     out_valid, btn_level[3], q_dmem);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({q_dmem, out_data, out_valid, btn_level} !== '0) begin
            errors++;
            $display("FAIL reset_async: q=%h od=%h ov=%b lvl=%b, required all zero",
                     q_dmem, out_data, out_valid, btn_level);
        end
        tick();
        btn_raw = '0;
        reset   = 1'b0;
    endtask

    task automatic test_debounce();
        apply_reset();
        btn_raw[2] = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            checks++;
            if (btn_level[2] !== 1'b0) begin
                errors++;
                $display("FAIL debounce_early edge %0d: got %b required 0", k, btn_level[2]);
            end
        end
        tick();
        checks++;
        if (btn_level[2] !== 1'b1) begin
            errors++;
            $display("FAIL debounce_edge6: got %b required 1", btn_level[2]);
        end
        btn_raw[0] = 1'b1;
        repeat (3) tick();
        btn_raw[0] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++;
            if (btn_level[0] !== 1'b0) begin
                errors++;
                $display("FAIL debounce_glitch cycle %0d: got %b required 0", k, btn_level[0]);
            end
        end
    endtask

    task automatic test_sticky();
        apply_reset();
        btn_raw[1] = 1'b1;
        repeat (7) tick();
        btn_raw[1] = 1'b0;
        repeat (7) tick();
        do_load(32'd4000);
        checks++;
        if (q_dmem !== 32'h2) begin
            errors++;
            $display("FAIL sticky_released_first: got %h required 00000002", q_dmem);
        end
        do_load(32'd4000);
        checks++;
        if (q_dmem !== 32'h0) begin
            errors++;
            $display("FAIL sticky_released_second: got %h required 00000000", q_dmem);
        end
        btn_raw[1] = 1'b1;
        repeat (7) tick();
        do_load(32'd4000);
        checks++;
        if (q_dmem !== 32'h3) begin
            errors++;
            $display("FAIL sticky_held_first: got %h required 00000003", q_dmem);
        end
        do_load(32'd4000);
        checks++;
        if (q_dmem !== 32'h1) begin
            errors++;
            $display("FAIL sticky_held_second: got %h required 00000001", q_dmem);
        end
    endtask

    task automatic test_set_wins();
        apply_reset();
        mem_q      = 32'h55;
        btn_raw[0] = 1'b1;
        repeat (5) tick();
        do_load(32'd3000);
        checks++;
        if (q_dmem !== 32'h0 || btn_level[0] !== 1'b1) begin
            errors++;
            $display("FAIL setwins_aligned: q=%h lvl0=%b required 00000000 1", q_dmem, btn_level[0]);
        end
        do_load(32'd3000);
        checks++;
        if (q_dmem !== 32'h3) begin
            errors++;
            $display("FAIL setwins_next: got %h required 00000003", q_dmem);
        end
    endtask

    task automatic test_out_store();
        apply_reset();
        do_store(32'd2000, 32'hDEADBEEF);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL store_pulse: ov=%b od=%h required 1 deadbeef", out_valid, out_data);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL store_pulse_end: ov=%b od=%h required 0 deadbeef", out_valid, out_data);
        end
        do_load(32'd2000);
        checks++;
        if (q_dmem !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL store_readback: got %h required deadbeef", q_dmem);
        end
        // Back-to-back stores
        address_dmem = 32'd2000;
        wren         = 1'b1;
        data         = 32'h1111_0001;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h1111_0001) begin
            errors++;
            $display("FAIL b2b_first: ov=%b od=%h required 1 11110001", out_valid, out_data);
        end
        data = 32'h2222_0002;
        tick();
        wren = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h2222_0002) begin
            errors++;
            $display("FAIL b2b_second: ov=%b od=%h required 1 22220002", out_valid, out_data);
        end
        // Store to a button address must not touch button state
        btn_raw[0] = 1'b1;
        repeat (7) tick();
        do_store(32'd3000, 32'hFFFF_FFFF);
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h2222_0002 || btn_level[0] !== 1'b1) begin
            errors++;
            $display("FAIL store_btn_addr: ov=%b od=%h lvl0=%b required 0 22220002 1",
                     out_valid, out_data, btn_level[0]);
        end
        do_load(32'd3000);
        checks++;
        if (q_dmem !== 32'h3) begin
            errors++;
            $display("FAIL store_btn_sticky: got %h required 00000003", q_dmem);
        end
    endtask

    task automatic test_pass_through();
        apply_reset();
        mem_q = 32'h1234;
        do_load(32'd12);
        checks++;
        if (q_dmem !== 32'h1234) begin
            errors++;
            $display("FAIL pass_load: got %h required 00001234", q_dmem);
        end
        mem_q = 32'hABCD;
        tick();
        checks++;
        if (q_dmem !== 32'hABCD) begin
            errors++;
            $display("FAIL pass_idle: got %h required 0000abcd", q_dmem);
        end
        btn_raw[0] = 1'b1;
        repeat (7) tick();
        address_dmem = 32'd3000;
        wren         = 1'b1;
        rden         = 1'b1;
        tick();
        wren         = 1'b0;
        rden         = 1'b0;
        do_load(32'd3000);
        checks++;
        if (q_dmem !== 32'h3) begin
            errors++;
            $display("FAIL pass_rw_sticky: got %h required 00000003", q_dmem);
        end
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_debounce();
        test_sticky();
        test_set_wins();
        test_out_store();
        test_pass_through();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
